// File: rtl/nucore_pkg.sv
// ---------------------------------------------------------------------------
// nucore_pkg : shared instruction-format widths and opcode constants
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package nucore_pkg;
  localparam int INST_W = 39;
  localparam int OPC_W  = 3;

  localparam logic [OPC_W-1:0] OPC_RST = 3'b000;
  localparam logic [OPC_W-1:0] OPC_ST1 = 3'b001;
  localparam logic [OPC_W-1:0] OPC_ST2 = 3'b010;
  localparam logic [OPC_W-1:0] OPC_ADD = 3'b011;
  localparam logic [OPC_W-1:0] OPC_AND = 3'b110;
endpackage

`default_nettype wire

// File: rtl/inst_queue_ram.sv
// ---------------------------------------------------------------------------
// inst_queue_ram : DEPTH x INST_W storage, synchronous write, async read
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module inst_queue_ram #(
  parameter int DEPTH  = 64,
  parameter int INST_W = 39,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [INST_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [INST_W-1:0] rd_data
);

  // No reset on the array: contents survive reset and flush by design.
  logic [INST_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

`default_nettype wire

// File: rtl/inst_fetch_queue.sv
// ---------------------------------------------------------------------------
// inst_fetch_queue : show-ahead instruction FIFO between loader and decoder
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module inst_fetch_queue #(
  parameter int INST_W   = nucore_pkg::INST_W,
  parameter int DEPTH    = 64,
  parameter int AF_LEVEL = DEPTH - 4,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_valid,
  input  logic [INST_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [INST_W-1:0] rd_data,
  output logic [2:0]        rd_opcode,
  input  logic              rd_ready,
  output logic [CNT_W-1:0]  count,
  output logic              almost_full,
  output logic              empty
);
  import nucore_pkg::*;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wr_acc, rd_acc, ram_wr_en;
  logic [INST_W-1:0] ram_rd_data;

  // Handshake outputs come from count_q only, never from wr_valid/rd_ready.
  assign wr_ready    = (count_q != CNT_W'(DEPTH));
  assign rd_valid    = (count_q != '0);
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= CNT_W'(AF_LEVEL));
  assign count       = count_q;

  assign wr_acc    = wr_valid && wr_ready;
  assign rd_acc    = rd_valid && rd_ready;
  assign ram_wr_en = wr_acc && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_acc && !rd_acc)      count_d = count_q + 1'b1;
      else if (rd_acc && !wr_acc) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  inst_queue_ram #(
    .DEPTH  (DEPTH),
    .INST_W (INST_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_rd_data)
  );

  // Empty queue presents zeros rather than stale storage.
  assign rd_data   = empty ? '0 : ram_rd_data;
  assign rd_opcode = rd_data[INST_W-1 -: OPC_W];

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_queue : directed checks for inst_fetch_queue (DEPTH = 64)
// Revision            : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_inst_fetch_queue;
  localparam int INST_W = 39;
  localparam int DEPTH  = 64;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              wr_valid;
  logic [INST_W-1:0] wr_data;
  logic              wr_ready;
  logic              rd_valid;
  logic [INST_W-1:0] rd_data;
  logic [2:0]        rd_opcode;
  logic              rd_ready;
  logic [CNT_W-1:0]  count;
  logic              almost_full;
  logic              empty;

  int n_checks = 0;
  int n_pass   = 0;

  inst_fetch_queue #(
    .INST_W   (INST_W),
    .DEPTH    (DEPTH),
    .AF_LEVEL (DEPTH - 4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_opcode   (rd_opcode),
    .rd_ready    (rd_ready),
    .count       (count),
    .almost_full (almost_full),
    .empty       (empty)
  );

  always #5 clk = ~clk;

  function automatic logic [INST_W-1:0] mk(input logic [2:0] op, input int idx);
    logic [3:0]  hi;
    logic [31:0] lo;
    hi = idx[3:0];
    lo = idx[31:0];
    return {op, hi, lo};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w_idx;
    int r_idx;
    rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    #3;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_wr_ready", 64'(wr_ready), 64'd1);
    chk("rst_af", 64'(almost_full), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_opcode", 64'(rd_opcode), 64'd0);
    step();
    rst = 1'b0;
    step();

    // Fill entries 1..10 with the decoder stalled.
    for (int i = 1; i <= 10; i++) begin
      wr_valid = 1'b1; wr_data = mk(3'b001, i);
      step();
    end
    wr_valid = 1'b0;
    chk("fill10_count", 64'(count), 64'd10);
    chk("fill10_opcode", 64'(rd_opcode), 64'd1);
    chk("fill10_low32", 64'(rd_data[31:0]), 64'd1);
    step();
    chk("stall_hold", 64'(rd_data), 64'(mk(3'b001, 1)));

    // Continue to full, watching the almost_full threshold.
    for (int i = 11; i <= 64; i++) begin
      wr_valid = 1'b1; wr_data = mk(3'b001, i);
      step();
      if (i == 59) chk("af_at_59", 64'(almost_full), 64'd0);
      if (i == 60) chk("af_at_60", 64'(almost_full), 64'd1);
    end
    chk("full_count", 64'(count), 64'd64);
    chk("full_wr_ready", 64'(wr_ready), 64'd0);
    wr_data = mk(3'b010, 65);
    step();
    chk("write65_refused", 64'(count), 64'd64);

    // Full with write and read together: only the read is taken.
    wr_data = mk(3'b010, 99); rd_ready = 1'b1;
    step();
    wr_valid = 1'b0; rd_ready = 1'b0;
    chk("full_rw_count", 64'(count), 64'd63);
    chk("full_rw_wr_ready", 64'(wr_ready), 64'd1);

    // Drain remaining 63 entries in order.
    rd_ready = 1'b1;
    for (int i = 2; i <= 64; i++) begin
      chk($sformatf("drain_%0d", i), 64'(rd_data), 64'(mk(3'b001, i)));
      step();
    end
    rd_ready = 1'b0;
    chk("drain_empty", 64'(empty), 64'd1);
    chk("drain_rd_data_zero", 64'(rd_data), 64'd0);

    // Steady state at count 3 for 200 cycles.
    w_idx = 0; r_idx = 0;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_data = mk(3'b011, w_idx); w_idx++;
      step();
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      wr_data = mk(3'b011, w_idx);
      chk("stream_data", 64'(rd_data), 64'(mk(3'b011, r_idx)));
      step();
      w_idx++; r_idx++;
    end
    wr_valid = 1'b0;
    chk("stream_count", 64'(count), 64'd3);
    for (int i = 0; i < 3; i++) begin
      chk("stream_tail", 64'(rd_data), 64'(mk(3'b011, r_idx)));
      step();
      r_idx++;
    end
    rd_ready = 1'b0;
    chk("stream_empty", 64'(empty), 64'd1);

    // Empty with write and read together: only the write is taken.
    wr_valid = 1'b1; rd_ready = 1'b1; wr_data = mk(3'b010, 3);
    chk("empty_no_bypass", 64'(rd_valid), 64'd0);
    step();
    rd_ready = 1'b0;
    chk("empty_rw_count", 64'(count), 64'd1);

    // Flush at count 5 beats concurrent write and read.
    for (int i = 0; i < 4; i++) begin
      wr_data = mk(3'b010, 10 + i);
      step();
    end
    chk("pre_flush_count", 64'(count), 64'd5);
    flush = 1'b1; rd_ready = 1'b1; wr_data = mk(3'b111, 15);
    step();
    flush = 1'b0; rd_ready = 1'b0; wr_valid = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_empty", 64'(empty), 64'd1);
    chk("flush_rd_valid", 64'(rd_valid), 64'd0);
    wr_valid = 1'b1; wr_data = mk(3'b100, 77);
    step();
    wr_valid = 1'b0;
    chk("post_flush_head", 64'(rd_data), 64'(mk(3'b100, 77)));
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;

    // Asynchronous reset mid-stream at count 7.
    for (int i = 0; i < 7; i++) begin
      wr_valid = 1'b1; wr_data = mk(3'b011, 40 + i);
      step();
    end
    wr_valid = 1'b0;
    chk("pre_rst_count", 64'(count), 64'd7);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_empty", 64'(empty), 64'd1);
    chk("async_rst_rd_data", 64'(rd_data), 64'd0);
    chk("async_rst_wr_ready", 64'(wr_ready), 64'd1);
    step();
    rst = 1'b0;
    wr_valid = 1'b1; wr_data = mk(3'b110, 5);
    step();
    wr_valid = 1'b0;
    chk("post_rst_opcode", 64'(rd_opcode), 64'd6);
    chk("post_rst_head", 64'(rd_data), 64'(mk(3'b110, 5)));
    chk("post_rst_count", 64'(count), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
